// File: rtl/benes_switch_loader_pkg.sv
// Shared types for the Benes switch-setting loader.
// Network size defaults and the loader FSM encoding live here.
package USER_PARAM_PKG;

    localparam int STAGE_NUM  = 9;
    localparam int SWITCH_NUM = 16;

    typedef logic [SWITCH_NUM-1:0] sw_stage_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_SWAP  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/benes_switch_loader_cfg_bank.sv
// Shadow register bank for one Benes network: per-stage settings
// plus a mask recording which stages the current program has written.
module benes_cfg_bank
    import USER_PARAM_PKG::*;
#(
    parameter int STAGE_NUM  = USER_PARAM_PKG::STAGE_NUM,
    parameter int SWITCH_NUM = USER_PARAM_PKG::SWITCH_NUM,
    parameter int STAGE_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [STAGE_W-1:0]    stage_i,
    input  logic [SWITCH_NUM-1:0] bits_i,
    input  logic                  mask_clr_i,
    output logic [SWITCH_NUM-1:0] shadow_o [0:STAGE_NUM-1],
    output logic [STAGE_NUM-1:0]  mask_o
);

    logic [SWITCH_NUM-1:0] shadow_q [0:STAGE_NUM-1];
    logic [STAGE_NUM-1:0]  mask_q;
    logic [STAGE_NUM-1:0]  mask_d;

    // Mark the written stage; a clear overrides a same-cycle write.
    always_comb begin
        mask_d = mask_q;
        if (we_i) begin
            mask_d[stage_i] = 1'b1;
        end
        if (mask_clr_i) begin
            mask_d = '0;
        end
    end

    // Shadow storage and mask; contents survive a commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGE_NUM; i++) begin
                shadow_q[i] <= '0;
            end
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
            if (we_i) begin
                shadow_q[stage_i] <= bits_i;
            end
        end
    end

    assign shadow_o = shadow_q;
    assign mask_o   = mask_q;

endmodule

// File: rtl/benes_switch_loader.sv
// Double-buffered switch-setting loader for two Benes networks.
// Define BENES_CFG_CHECK_EN to reject programs missing any stage.
module benes_switch_loader
    import USER_PARAM_PKG::*;
#(
    parameter int STAGE_NUM  = USER_PARAM_PKG::STAGE_NUM,
    parameter int SWITCH_NUM = USER_PARAM_PKG::SWITCH_NUM,
    localparam int STAGE_W   = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic                  cfg_net,
    input  logic [STAGE_W-1:0]    cfg_stage,
    input  logic [SWITCH_NUM-1:0] cfg_bits,
    input  logic                  cfg_last,
    input  logic                  commit_req,
    output logic                  commit_ack,
    output logic                  cfg_err,
    input  logic                  err_clr,
    output logic [SWITCH_NUM-1:0] slot_select   [0:STAGE_NUM-1],
    output logic [SWITCH_NUM-1:0] module_select [0:STAGE_NUM-1]
);

    loader_state_t state_q, state_d;
    logic          err_q, err_d;
    logic          beat, stage_ok, new_err;
    logic          we_slot, we_mod, mask_clr, commit;

    logic [SWITCH_NUM-1:0] sh_slot [0:STAGE_NUM-1];
    logic [SWITCH_NUM-1:0] sh_mod  [0:STAGE_NUM-1];
    logic [SWITCH_NUM-1:0] act_slot_q [0:STAGE_NUM-1];
    logic [SWITCH_NUM-1:0] act_mod_q  [0:STAGE_NUM-1];
    logic [STAGE_NUM-1:0]  mask_slot, mask_mod;

    assign cfg_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
    assign beat      = cfg_valid & cfg_ready;
    assign stage_ok  = int'(cfg_stage) < STAGE_NUM;
    assign we_slot   = beat & stage_ok & ~cfg_net;
    assign we_mod    = beat & stage_ok & cfg_net;

`ifdef BENES_CFG_CHECK_EN
    logic [STAGE_NUM-1:0] hot;
    logic                 complete;

    // Program is complete when both masks, including this beat, are full.
    always_comb begin
        hot      = STAGE_NUM'(1) << cfg_stage;
        complete = (&(mask_slot | (we_slot ? hot : '0)))
                 & (&(mask_mod  | (we_mod  ? hot : '0)));
    end
`endif

    benes_cfg_bank #(
        .STAGE_NUM (STAGE_NUM),
        .SWITCH_NUM(SWITCH_NUM),
        .STAGE_W   (STAGE_W)
    ) u_bank_slot (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we_slot),
        .stage_i   (cfg_stage),
        .bits_i    (cfg_bits),
        .mask_clr_i(mask_clr),
        .shadow_o  (sh_slot),
        .mask_o    (mask_slot)
    );

    benes_cfg_bank #(
        .STAGE_NUM (STAGE_NUM),
        .SWITCH_NUM(SWITCH_NUM),
        .STAGE_W   (STAGE_W)
    ) u_bank_mod (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we_mod),
        .stage_i   (cfg_stage),
        .bits_i    (cfg_bits),
        .mask_clr_i(mask_clr),
        .shadow_o  (sh_mod),
        .mask_o    (mask_mod)
    );

    // Loader FSM next state, commit strobe and error detection.
    always_comb begin
        state_d  = state_q;
        mask_clr = 1'b0;
        commit   = 1'b0;
        new_err  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (beat) begin
                    new_err = ~stage_ok;
                    state_d = ST_LOAD;
                    if (cfg_last) begin
`ifdef BENES_CFG_CHECK_EN
                        if (complete) begin
                            state_d = ST_ARMED;
                        end else begin
                            new_err  = 1'b1;
                            mask_clr = 1'b1;
                            state_d  = ST_IDLE;
                        end
`else
                        state_d = ST_ARMED;
`endif
                    end
                end
            end
            ST_ARMED: begin
                if (commit_req) begin
                    commit  = 1'b1;
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                mask_clr = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky error: a new error outranks a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (new_err) begin
            err_d = 1'b1;
        end
    end

    // State and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Active settings change only on the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGE_NUM; i++) begin
                act_slot_q[i] <= '0;
                act_mod_q[i]  <= '0;
            end
        end else if (commit) begin
            act_slot_q <= sh_slot;
            act_mod_q  <= sh_mod;
        end
    end

    assign commit_ack    = (state_q == ST_SWAP);
    assign cfg_err       = err_q;
    assign slot_select   = act_slot_q;
    assign module_select = act_mod_q;

endmodule

// File: tb/tb_benes_switch_loader.sv
// Scoreboard bench for benes_switch_loader (9 stages x 16 switches).
// Compile with BENES_CFG_CHECK_EN to match a checked-program build.
module tb_benes_switch_loader;

    localparam int NS = 9;

    typedef struct {
        int          cyc;
        logic [15:0] s [NS];
        logic [15:0] m [NS];
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic        clk, rst;
    logic        cfg_valid, cfg_ready, cfg_net;
    logic [3:0]  cfg_stage;
    logic [15:0] cfg_bits;
    logic        cfg_last, commit_req, commit_ack;
    logic        cfg_err, err_clr;
    logic [15:0] slot_select   [0:NS-1];
    logic [15:0] module_select [0:NS-1];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t exp_q [$];
    chk_t chk_q [$];

    // reference model state
    logic [15:0] m_shadow [2][NS];
    logic [15:0] m_active [2][NS];
    bit          m_wr     [2][NS];
    bit          m_armed, m_swap, m_err;

    benes_switch_loader dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_net      (cfg_net),
        .cfg_stage    (cfg_stage),
        .cfg_bits     (cfg_bits),
        .cfg_last     (cfg_last),
        .commit_req   (commit_req),
        .commit_ack   (commit_ack),
        .cfg_err      (cfg_err),
        .err_clr      (err_clr),
        .slot_select  (slot_select),
        .module_select(module_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: programs, commits and errors per edge.
    always @(posedge clk or posedge rst) begin : model
        bit   rdy, nerr, all;
        exp_t e;
        if (rst) begin
            for (int n = 0; n < 2; n++)
                for (int s = 0; s < NS; s++) begin
                    m_shadow[n][s] = '0;
                    m_active[n][s] = '0;
                    m_wr[n][s]     = 1'b0;
                end
            m_armed = 0;
            m_swap  = 0;
            m_err   = 0;
            exp_q.delete();
        end else begin
            rdy  = !m_armed && !m_swap;
            nerr = 0;
            if (m_swap) begin
                m_swap = 0;
                for (int n = 0; n < 2; n++)
                    for (int s = 0; s < NS; s++) m_wr[n][s] = 0;
            end else if (m_armed && commit_req) begin
                e.cyc = cyc + 1;
                for (int s = 0; s < NS; s++) begin
                    e.s[s] = m_shadow[0][s];
                    e.m[s] = m_shadow[1][s];
                end
                exp_q.push_back(e);
                m_active = m_shadow;
                m_armed  = 0;
                m_swap   = 1;
            end else if (cfg_valid && rdy) begin
                if (int'(cfg_stage) < NS) begin
                    m_shadow[cfg_net][cfg_stage] = cfg_bits;
                    m_wr[cfg_net][cfg_stage]     = 1;
                end else begin
                    nerr = 1;
                end
                if (cfg_last) begin
                    all = 1;
                    for (int n = 0; n < 2; n++)
                        for (int s = 0; s < NS; s++)
                            if (!m_wr[n][s]) all = 0;
`ifdef BENES_CFG_CHECK_EN
                    if (!all) begin
                        nerr = 1;
                        for (int n = 0; n < 2; n++)
                            for (int s = 0; s < NS; s++)
                                m_wr[n][s] = 0;
                    end else begin
                        m_armed = 1;
                    end
`else
                    m_armed = 1;
`endif
                end
            end
            if (err_clr) m_err = 0;
            if (nerr)    m_err = 1;
        end
    end

    // Monitor: compares DUT against model and scoreboard queues.
    always @(negedge clk) begin : mon
        exp_t e;
        chk_t c;
        bit   bad;
        checks++;
        if (cfg_ready !== (!rst && !m_armed && !m_swap)) begin
            errors++;
            $display("FAIL ready: got %b want %b", cfg_ready,
                     !rst && !m_armed && !m_swap);
        end
        checks++;
        if (cfg_err !== m_err) begin
            errors++;
            $display("FAIL err: got %b want %b", cfg_err, m_err);
        end
        bad = 0;
        for (int s = 0; s < NS; s++)
            if (slot_select[s] !== m_active[0][s] ||
                module_select[s] !== m_active[1][s]) bad = 1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL active: slot0=%h mod0=%h want %h %h",
                     slot_select[0], module_select[0],
                     m_active[0][0], m_active[1][0]);
        end
        if (commit_ack === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ack: got unexpected ack at cyc %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL ack_cyc: got %0d want %0d", cyc, e.cyc);
                end
                bad = 0;
                for (int s = 0; s < NS; s++)
                    if (slot_select[s] !== e.s[s] ||
                        module_select[s] !== e.m[s]) bad = 1;
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL ack_data: slot8=%h mod8=%h want %h %h",
                             slot_select[8], module_select[8],
                             e.s[8], e.m[8]);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL ack: got none want ack at cyc %0d",
                     exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        while (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            checks++;
            if (c.act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %0h want %0h",
                         c.name, c.act, c.exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic beat(input bit net, input int stage,
                        input logic [15:0] bits, input bit last,
                        input bit creq);
        cfg_valid  = 1'b1;
        cfg_net    = net;
        cfg_stage  = 4'(stage);
        cfg_bits   = bits;
        cfg_last   = last;
        commit_req = creq;
        step();
        cfg_valid  = 1'b0;
        cfg_last   = 1'b0;
        commit_req = 1'b0;
    endtask

    task automatic commit();
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
    endtask

    // Full 18-beat program, bits = base + 0x1000*net + stage.
    task automatic load_prog(input logic [15:0] base, input bit creq);
        for (int n = 0; n < 2; n++)
            for (int s = 0; s < NS; s++)
                beat(n[0], s, base + 16'(16'h1000 * n + s),
                     (n == 1 && s == NS - 1),
                     creq && (n == 1 && s == NS - 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_net    = 1'b0;
        cfg_stage  = '0;
        cfg_bits   = '0;
        cfg_last   = 1'b0;
        commit_req = 1'b0;
        err_clr    = 1'b0;
        idle(3);
        chk("rst_ready", 32'(cfg_ready), 0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", 32'(cfg_ready), 1);
        chk("err_after_rst", 32'(cfg_err), 0);
        chk("slot0_rst", 32'(slot_select[0]), 0);

        // full program and commit
        load_prog(16'h0000, 1'b0);
        chk("armed_ready", 32'(cfg_ready), 0);
        commit();
        idle(2);
        chk("slot3", 32'(slot_select[3]), 32'h0003);
        chk("mod8", 32'(module_select[8]), 32'h1008);

        // out-of-range stage
        beat(1'b0, 12, 16'hBEEF, 1'b0, 1'b0);
        chk("bad_stage_err", 32'(cfg_err), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_cleared", 32'(cfg_err), 0);

        // commit_req held in LOAD yields nothing
        commit_req = 1'b1;
        idle(3);
        commit_req = 1'b0;
        chk("load_ready", 32'(cfg_ready), 1);

        // last with commit_req in the same cycle
        load_prog(16'h0200, 1'b1);
        commit();
        idle(2);
        chk("mod4_prog2", 32'(module_select[4]), 32'h1204);

        // 17 distinct stages, then last rewriting a stage
        for (int n = 0; n < 2; n++)
            for (int s = 0; s < NS; s++)
                if (!(n == 1 && s == NS - 1))
                    beat(n[0], s, 16'(16'h0400 + 16 * n + s),
                         1'b0, 1'b0);
        beat(1'b1, 7, 16'h0ABC, 1'b1, 1'b0);
        commit();
        idle(2);
`ifdef BENES_CFG_CHECK_EN
        chk("partial_err", 32'(cfg_err), 1);
        chk("partial_mod7", 32'(module_select[7]), 32'h1207);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
`else
        chk("partial_err", 32'(cfg_err), 0);
        chk("partial_mod7", 32'(module_select[7]), 32'h0ABC);
        chk("partial_mod8", 32'(module_select[8]), 32'h1208);
`endif

        // reset while armed
        load_prog(16'h0500, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rst_slot3", 32'(slot_select[3]), 0);
        chk("rst_ready2", 32'(cfg_ready), 1);
        commit();
        idle(2);
        load_prog(16'h0300, 1'b0);
        commit();
        idle(2);
        chk("mod5_after_rst", 32'(module_select[5]), 32'h1305);

        // randomized programs
        for (int it = 0; it < 40; it++) begin
            int len;
            len = $urandom_range(1, 22);
            for (int j = 0; j < len; j++)
                beat($urandom_range(0, 1) == 1, $urandom_range(0, 10),
                     16'($urandom), j == len - 1, 1'b0);
            if ($urandom_range(0, 7) == 0) begin
                err_clr = 1'b1;
                step();
                err_clr = 1'b0;
            end
            if ($urandom_range(0, 3) != 0) commit();
            idle($urandom_range(1, 3));
        end

        idle(3);
        chk("ack_queue_left", 32'(exp_q.size()), 0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
